// File: rtl/music_pkg.sv
// Shared definitions for the song sequencer: silence tone code, controller
// state encoding, tempo select encodings and defaults, plus the helper that
// turns a tempo selection into a tick-counter limit.
package music_pkg;

  localparam logic [31:0] SILENCE_TONE     = 32'd20000;
  localparam int unsigned DEF_SONG_LEN     = 108;
  localparam int unsigned DEF_TICK_CYCLES  = 12_500_000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PLAY  = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    TEMPO_NORMAL     = 2'd0,
    TEMPO_DOUBLE     = 2'd1,
    TEMPO_HALF       = 2'd2,
    TEMPO_NORMAL_ALT = 2'd3
  } tempo_e;

  // Cycles per quarter-beat for a tempo selection; never returns 0 so the
  // tick compare (limit-1) cannot underflow.
  function automatic logic [31:0] tempo_limit(input logic [1:0] sel,
                                              input logic [31:0] base);
    logic [31:0] lim;
    case (tempo_e'(sel))
      TEMPO_DOUBLE: lim = base >> 1;
      TEMPO_HALF:   lim = base << 1;
      default:      lim = base;
    endcase
    if (lim == 32'd0) lim = 32'd1;
    return lim;
  endfunction

endpackage

// File: rtl/beat_sequencer_ctrl_if.sv
// Bundle of control inputs, song ROM handshake and buzzer outputs of the
// beat sequencer.
//   slave  : the sequencer (takes controls and ROM tone, drives beat/tone/status)
//   master : the surrounding logic (debouncers, ROM, PWM)
interface beat_sequencer_ctrl_if;
  logic        play;
  logic        pause;
  logic        stop;
  logic        loop_en;
  logic [1:0]  tempo_sel;
  logic [31:0] tone_in;
  logic [7:0]  beat_num;
  logic [31:0] tone_out;
  logic        playing;
  logic        note_start;
  logic        done;

  modport slave (
    input  play, pause, stop, loop_en, tempo_sel, tone_in,
    output beat_num, tone_out, playing, note_start, done
  );

  modport master (
    output play, pause, stop, loop_en, tempo_sel, tone_in,
    input  beat_num, tone_out, playing, note_start, done
  );
endinterface

// File: rtl/beat_sequencer_ctrl_tick_gen.sv
// Quarter-beat tick generator.
//   clk, rst  : clock, synchronous active-high reset
//   clear_i   : force counter to 0 (wins over enable)
//   enable_i  : count this cycle; when low the counter holds
//   limit_i   : cycles per tick (>= 1)
//   tick_o    : high in the cycle the counter sits at limit-1 while enabled
module tick_gen (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear_i,
  input  logic        enable_i,
  input  logic [31:0] limit_i,
  output logic        tick_o
);

  logic [31:0] cnt_q, cnt_d;

  // >= rather than == so a counter held across a tempo change to a shorter
  // limit still terminates instead of running to wrap-around.
  assign tick_o = enable_i && (cnt_q >= (limit_i - 32'd1));

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i)       cnt_d = '0;
    else if (tick_o)   cnt_d = '0;
    else if (enable_i) cnt_d = cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/beat_sequencer_ctrl.sv
// Song sequencer controller: steps the beat index into the song ROM at the
// selected tempo, registers the returned tone for the buzzer PWM and handles
// play/pause/stop/loop. Outputs the silence code whenever not playing.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of beat_sequencer_ctrl_if (controls, ROM, PWM)
//
// state    | meaning
// ---------+---------------------------------------------------------
// ST_IDLE  | stopped at beat 0, silent
// ST_PLAY  | counting ticks, advancing beats, tone follows the ROM
// ST_PAUSE | beat and tick counter frozen, silent
// ST_DONE  | song ended without loop, silent, waiting for play/stop
module beat_sequencer_ctrl
  import music_pkg::*;
#(
  parameter int unsigned TICK_CYCLES = DEF_TICK_CYCLES,
  parameter int unsigned SONG_LEN    = DEF_SONG_LEN,
  parameter logic [31:0] SILENCE     = SILENCE_TONE
) (
  input  logic                 clk,
  input  logic                 rst,
  beat_sequencer_ctrl_if.slave bus
);

  localparam logic [7:0]  LAST_BEAT = 8'(SONG_LEN - 1);
  localparam logic [31:0] BASE_LIM  = 32'(TICK_CYCLES);

  state_e      state_q, state_d;
  logic [7:0]  beat_q, beat_d;
  logic [31:0] limit_q, limit_d;
  logic [31:0] tone_q, tone_d;
  logic        playing_q, playing_d;
  logic        note_start_q, note_start_d;
  logic        done_q, done_d;
  logic        cnt_clear, cnt_en, tick;

  // Pause/stop freeze the counter in the same cycle, so a tick coinciding
  // with either control never fires.
  assign cnt_en = (state_q == ST_PLAY) && !bus.stop && !bus.pause;

  tick_gen u_tick_gen (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (cnt_clear),
    .enable_i (cnt_en),
    .limit_i  (limit_q),
    .tick_o   (tick)
  );

  always_comb begin
    state_d      = state_q;
    beat_d       = beat_q;
    limit_d      = limit_q;
    note_start_d = 1'b0;
    done_d       = 1'b0;
    cnt_clear    = 1'b0;

    if (bus.stop) begin
      state_d   = ST_IDLE;
      beat_d    = '0;
      cnt_clear = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (bus.play) begin
            state_d      = ST_PLAY;
            beat_d       = '0;
            cnt_clear    = 1'b1;
            note_start_d = 1'b1;
            limit_d      = tempo_limit(bus.tempo_sel, BASE_LIM);
          end
        end
        ST_PLAY: begin
          if (bus.pause) begin
            state_d = ST_PAUSE;
          end else if (tick) begin
            limit_d = tempo_limit(bus.tempo_sel, BASE_LIM);
            if (beat_q < LAST_BEAT) begin
              beat_d       = beat_q + 8'd1;
              note_start_d = 1'b1;
            end else if (bus.loop_en) begin
              beat_d       = '0;
              note_start_d = 1'b1;
            end else begin
              state_d = ST_DONE;
              beat_d  = '0;
              done_d  = 1'b1;
            end
          end
        end
        ST_PAUSE: begin
          if (bus.play) begin
            state_d = ST_PLAY;
            limit_d = tempo_limit(bus.tempo_sel, BASE_LIM);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // Tone tracks the ROM only while staying in PLAY; leaving PLAY silences
    // the buzzer on the same edge rather than one cycle later.
    tone_d    = ((state_q == ST_PLAY) && (state_d == ST_PLAY)) ? bus.tone_in : SILENCE;
    playing_d = (state_d == ST_PLAY);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      beat_q       <= '0;
      limit_q      <= tempo_limit(2'd0, BASE_LIM);
      tone_q       <= SILENCE;
      playing_q    <= 1'b0;
      note_start_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      limit_q      <= limit_d;
      tone_q       <= tone_d;
      playing_q    <= playing_d;
      note_start_q <= note_start_d;
      done_q       <= done_d;
    end
  end

  assign bus.beat_num   = beat_q;
  assign bus.tone_out   = tone_q;
  assign bus.playing    = playing_q;
  assign bus.note_start = note_start_q;
  assign bus.done       = done_q;

endmodule

// File: tb/tb_beat_sequencer_ctrl.sv
module tb_beat_sequencer_ctrl;

  localparam logic [31:0] SIL = 32'd20000;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  beat_sequencer_ctrl_if bus();

  // ROM model: tone = 100 + beat
  assign bus.tone_in = 32'd100 + 32'(bus.beat_num);

  beat_sequencer_ctrl #(.TICK_CYCLES(4), .SONG_LEN(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_play();
    bus.play = 1'b1; step(); bus.play = 1'b0;
  endtask

  task automatic pulse_stop();
    bus.stop = 1'b1; step(); bus.stop = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.play = 0; bus.pause = 0; bus.stop = 0; bus.loop_en = 0; bus.tempo_sel = 2'd0;
    step(); step();
    checks++; if (bus.beat_num !== 8'd0) begin errors++; $display("FAIL reset beat_num got %0d exp 0", bus.beat_num); end
    checks++; if (bus.tone_out !== SIL) begin errors++; $display("FAIL reset tone_out got %0d exp %0d", bus.tone_out, SIL); end
    checks++; if (bus.playing !== 1'b0) begin errors++; $display("FAIL reset playing got %b exp 0", bus.playing); end
    checks++; if (bus.note_start !== 1'b0) begin errors++; $display("FAIL reset note_start got %b exp 0", bus.note_start); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset done got %b exp 0", bus.done); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_play_to_end();
    int ns_cnt, done_cnt;
    logic [7:0]  eb;
    logic [31:0] et;
    pulse_play();
    ns_cnt = 0; done_cnt = 0;
    checks++; if (bus.playing !== 1'b1) begin errors++; $display("FAIL play_start playing got %b exp 1", bus.playing); end
    checks++; if (bus.note_start !== 1'b1) begin errors++; $display("FAIL play_start note_start got %b exp 1", bus.note_start); end
    checks++; if (bus.tone_out !== SIL) begin errors++; $display("FAIL play_start tone_out got %0d exp %0d", bus.tone_out, SIL); end
    if (bus.note_start === 1'b1) ns_cnt++;
    for (int n = 1; n <= 25; n++) begin
      step();
      eb = (n < 24) ? 8'(n / 4) : 8'd0;
      et = (n < 24) ? 32'(100 + (n - 1) / 4) : SIL;
      checks++; if (bus.beat_num !== eb) begin errors++; $display("FAIL play_end beat n=%0d got %0d exp %0d", n, bus.beat_num, eb); end
      checks++; if (bus.tone_out !== et) begin errors++; $display("FAIL play_end tone n=%0d got %0d exp %0d", n, bus.tone_out, et); end
      checks++; if (bus.note_start !== ((n < 24) && (n % 4 == 0))) begin errors++; $display("FAIL play_end note_start n=%0d got %b", n, bus.note_start); end
      checks++; if (bus.done !== (n == 24)) begin errors++; $display("FAIL play_end done n=%0d got %b", n, bus.done); end
      checks++; if (bus.playing !== (n < 24)) begin errors++; $display("FAIL play_end playing n=%0d got %b", n, bus.playing); end
      if (bus.note_start === 1'b1) ns_cnt++;
      if (bus.done === 1'b1) done_cnt++;
    end
    checks++; if (ns_cnt != 6) begin errors++; $display("FAIL play_end note_start_count got %0d exp 6", ns_cnt); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL play_end done_count got %0d exp 1", done_cnt); end
  endtask

  // Starts from DONE (left by the previous test).
  task automatic test_loop();
    int ns_cnt, done_cnt;
    logic [7:0]  eb;
    logic [31:0] et;
    bus.loop_en = 1'b1;
    pulse_play();
    ns_cnt = 0; done_cnt = 0;
    checks++; if (bus.note_start !== 1'b1 || bus.beat_num !== 8'd0) begin errors++; $display("FAIL loop_start ns=%b beat=%0d exp ns=1 beat=0", bus.note_start, bus.beat_num); end
    if (bus.note_start === 1'b1) ns_cnt++;
    for (int n = 1; n <= 72; n++) begin
      step();
      eb = 8'((n / 4) % 6);
      et = 32'(100 + ((n - 1) / 4) % 6);
      checks++; if (bus.beat_num !== eb) begin errors++; $display("FAIL loop beat n=%0d got %0d exp %0d", n, bus.beat_num, eb); end
      checks++; if (bus.tone_out !== et) begin errors++; $display("FAIL loop tone n=%0d got %0d exp %0d", n, bus.tone_out, et); end
      checks++; if (bus.note_start !== (n % 4 == 0)) begin errors++; $display("FAIL loop note_start n=%0d got %b", n, bus.note_start); end
      if (bus.note_start === 1'b1) ns_cnt++;
      if (bus.done === 1'b1) done_cnt++;
    end
    checks++; if (ns_cnt != 19) begin errors++; $display("FAIL loop note_start_count got %0d exp 19", ns_cnt); end
    checks++; if (done_cnt != 0) begin errors++; $display("FAIL loop done_count got %0d exp 0", done_cnt); end
    pulse_stop();
    bus.loop_en = 1'b0;
    checks++; if (bus.playing !== 1'b0 || bus.beat_num !== 8'd0 || bus.tone_out !== SIL) begin errors++; $display("FAIL loop_stop playing=%b beat=%0d tone=%0d exp 0/0/%0d", bus.playing, bus.beat_num, bus.tone_out, SIL); end
  endtask

  task automatic test_pause_resume();
    pulse_play();
    for (int n = 1; n <= 14; n++) step();
    bus.pause = 1'b1; step(); bus.pause = 1'b0;
    checks++; if (bus.playing !== 1'b0) begin errors++; $display("FAIL pause playing got %b exp 0", bus.playing); end
    checks++; if (bus.beat_num !== 8'd3) begin errors++; $display("FAIL pause beat got %0d exp 3", bus.beat_num); end
    checks++; if (bus.tone_out !== SIL) begin errors++; $display("FAIL pause tone got %0d exp %0d", bus.tone_out, SIL); end
    for (int i = 0; i < 20; i++) begin
      step();
      checks++; if (bus.beat_num !== 8'd3 || bus.tone_out !== SIL) begin errors++; $display("FAIL pause_hold i=%0d beat=%0d tone=%0d exp 3/%0d", i, bus.beat_num, bus.tone_out, SIL); end
    end
    pulse_play();
    checks++; if (bus.playing !== 1'b1 || bus.beat_num !== 8'd3 || bus.note_start !== 1'b0) begin errors++; $display("FAIL resume0 playing=%b beat=%0d ns=%b exp 1/3/0", bus.playing, bus.beat_num, bus.note_start); end
    step();
    checks++; if (bus.beat_num !== 8'd3 || bus.tone_out !== 32'd103) begin errors++; $display("FAIL resume1 beat=%0d tone=%0d exp 3/103", bus.beat_num, bus.tone_out); end
    step();
    checks++; if (bus.beat_num !== 8'd4 || bus.note_start !== 1'b1) begin errors++; $display("FAIL resume2 beat=%0d ns=%b exp 4/1", bus.beat_num, bus.note_start); end
    step();
    checks++; if (bus.tone_out !== 32'd104) begin errors++; $display("FAIL resume3 tone got %0d exp 104", bus.tone_out); end
    pulse_stop();
  endtask

  task automatic test_tempo();
    int bnd [7] = '{4, 8, 12, 14, 16, 24, 32};
    int cnt;
    logic is_b;
    bus.loop_en = 1'b1;
    bus.tempo_sel = 2'd0;
    pulse_play();
    for (int n = 1; n <= 33; n++) begin
      step();
      cnt = 0; is_b = 1'b0;
      for (int k = 0; k < 7; k++) begin
        if (bnd[k] <= n) cnt++;
        if (bnd[k] == n) is_b = 1'b1;
      end
      checks++; if (bus.beat_num !== 8'(cnt % 6)) begin errors++; $display("FAIL tempo beat n=%0d got %0d exp %0d", n, bus.beat_num, cnt % 6); end
      checks++; if (bus.note_start !== is_b) begin errors++; $display("FAIL tempo note_start n=%0d got %b exp %b", n, bus.note_start, is_b); end
      if (n == 9)  bus.tempo_sel = 2'd1;
      if (n == 14) bus.tempo_sel = 2'd2;
    end
    pulse_stop();
    bus.tempo_sel = 2'd0;
    bus.loop_en = 1'b0;
  endtask

  task automatic test_stop_pause_on_tick();
    pulse_play();
    step(); step(); step();
    bus.stop = 1'b1; step(); bus.stop = 1'b0;
    checks++; if (bus.beat_num !== 8'd0 || bus.note_start !== 1'b0 || bus.done !== 1'b0) begin errors++; $display("FAIL stop_tick beat=%0d ns=%b done=%b exp 0/0/0", bus.beat_num, bus.note_start, bus.done); end
    checks++; if (bus.playing !== 1'b0 || bus.tone_out !== SIL) begin errors++; $display("FAIL stop_tick playing=%b tone=%0d exp 0/%0d", bus.playing, bus.tone_out, SIL); end
    step(); step();
    checks++; if (bus.beat_num !== 8'd0 || bus.note_start !== 1'b0) begin errors++; $display("FAIL stop_idle beat=%0d ns=%b exp 0/0", bus.beat_num, bus.note_start); end
    pulse_play();
    step(); step(); step();
    bus.pause = 1'b1; step(); bus.pause = 1'b0;
    checks++; if (bus.beat_num !== 8'd0 || bus.note_start !== 1'b0 || bus.playing !== 1'b0) begin errors++; $display("FAIL pause_tick beat=%0d ns=%b playing=%b exp 0/0/0", bus.beat_num, bus.note_start, bus.playing); end
    step(); step(); step();
    pulse_play();
    checks++; if (bus.beat_num !== 8'd0 || bus.playing !== 1'b1) begin errors++; $display("FAIL pause_tick_resume beat=%0d playing=%b exp 0/1", bus.beat_num, bus.playing); end
    step();
    checks++; if (bus.beat_num !== 8'd1 || bus.note_start !== 1'b1) begin errors++; $display("FAIL pause_tick_adv beat=%0d ns=%b exp 1/1", bus.beat_num, bus.note_start); end
    pulse_stop();
  endtask

  task automatic test_reset_mid_play();
    pulse_play();
    for (int n = 1; n <= 9; n++) step();
    checks++; if (bus.beat_num !== 8'd2 || bus.tone_out !== 32'd102) begin errors++; $display("FAIL pre_rst beat=%0d tone=%0d exp 2/102", bus.beat_num, bus.tone_out); end
    rst = 1'b1; bus.play = 1'b1; step(); bus.play = 1'b0;
    checks++; if (bus.beat_num !== 8'd0 || bus.tone_out !== SIL || bus.playing !== 1'b0) begin errors++; $display("FAIL rst_mid beat=%0d tone=%0d playing=%b exp 0/%0d/0", bus.beat_num, bus.tone_out, bus.playing, SIL); end
    checks++; if (bus.note_start !== 1'b0 || bus.done !== 1'b0) begin errors++; $display("FAIL rst_mid ns=%b done=%b exp 0/0", bus.note_start, bus.done); end
    rst = 1'b0;
    step();
    pulse_play();
    checks++; if (bus.note_start !== 1'b1 || bus.beat_num !== 8'd0) begin errors++; $display("FAIL rst_restart ns=%b beat=%0d exp 1/0", bus.note_start, bus.beat_num); end
    step(); step(); step(); step();
    checks++; if (bus.beat_num !== 8'd1 || bus.note_start !== 1'b1) begin errors++; $display("FAIL rst_restart_adv beat=%0d ns=%b exp 1/1", bus.beat_num, bus.note_start); end
    pulse_stop();
  endtask

  initial begin
    test_reset();
    test_play_to_end();
    test_loop();
    test_pause_resume();
    test_tempo();
    test_stop_pause_on_tick();
    test_reset_mid_play();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
